lc4_issue_scoreboard: RTL

//  Issue-stage scoreboard between lc4_decoder and the multi-cycle execute/ECC units.

---
 rtl/lc4_issue_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/lc4_issue_scoreboard.sv
// lc4_issue_scoreboard
//   Issue-stage scoreboard between the decoder and the multi-cycle execute/ECC
//   units. It tracks in-flight writes to the regfile and NZP, and stalls decode
//   on RAW/WAW hazards, on a branch that reads a pending NZP, and on a full
//   in-flight window. Control insns wait (DRAIN) until the pipe is empty.
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   id_valid                : decode holds a valid insn
//   r1sel/r1re, r2sel/r2re  : source selects and read enables
//   wsel, regfile_we        : destination select and write enable
//   nzp_we, is_branch       : insn writes / reads NZP
//   is_control_insn         : insn requires an empty pipe
//   wb_valid/wb_sel/wb_we/wb_nzp : one writer retiring this cycle
//   issue                   : insn accepted this cycle (combinational)
//   stall                   : id_valid & ~issue
//   pending, nzp_pending    : registered pending-write state
//   inflight                : outstanding writer count
//   draining                : FSM is in DRAIN
//   err                     : sticky writeback protocol error
module lc4_issue_scoreboard #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned SEL_W        = 5,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [SEL_W-1:0] r1sel,
  input  logic [SEL_W-1:0] r2sel,
  input  logic             r1re,
  input  logic             r2re,
  input  logic [SEL_W-1:0] wsel,
  input  logic             regfile_we,
  input  logic             nzp_we,
  input  logic             is_branch,
  input  logic             is_control_insn,
  input  logic             wb_valid,
  input  logic [SEL_W-1:0] wb_sel,
  input  logic             wb_we,
  input  logic             wb_nzp,
  output logic             issue,
  output logic             stall,
  output logic [NREGS-1:0] pending,
  output logic             nzp_pending,
  output logic [CNT_W-1:0] inflight,
  output logic             draining,
  output logic             err
);

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;

  logic [NREGS-1:0] clr, set, eff;
  logic             eff_nzp, writer, full, hazard, ctrl_wait;
  logic             inc, dec, inflight_zero;

  assign inflight_zero = (inflight == '0);
  assign writer        = regfile_we | nzp_we;

  // A retiring writer clears its bit in the same cycle, so hazard checks
  // look at the post-writeback view of the pending state.
  always_comb begin
    clr = '0;
    if (wb_valid && wb_we) clr[wb_sel] = 1'b1;
  end

  assign eff     = pending & ~clr;
  assign eff_nzp = nzp_pending & ~(wb_valid & wb_nzp);

  // A retirement this cycle frees a slot, so a full window does not block.
  assign full = writer & (inflight == CNT_W'(MAX_INFLIGHT)) & ~wb_valid;

  assign hazard = (r1re & eff[r1sel]) | (r2re & eff[r2sel])
                | (regfile_we & eff[wsel]) | (is_branch & eff_nzp) | full;

  assign ctrl_wait = is_control_insn & ~inflight_zero;

  assign issue    = ~rst & (state == RUN) & id_valid & ~hazard & ~ctrl_wait;
  assign stall    = id_valid & ~issue;
  assign draining = (state == DRAIN);

  always_comb begin
    set = '0;
    if (issue && regfile_we) set[wsel] = 1'b1;
  end

  assign inc = issue & writer;
  assign dec = wb_valid & ~inflight_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      nzp_pending <= 1'b0;
      inflight    <= '0;
      err         <= 1'b0;
      state       <= RUN;
    end else begin
      // Set is OR-ed after the clear so a new writer owns the bit.
      pending     <= (pending & ~clr) | set;
      nzp_pending <= eff_nzp | (issue & nzp_we);

      if (inc && !dec)      inflight <= inflight + CNT_W'(1);
      else if (dec && !inc) inflight <= inflight - CNT_W'(1);

      if ((wb_valid && inflight_zero) || (wb_valid && wb_we && !pending[wb_sel]))
        err <= 1'b1;

      case (state)
        RUN:     if (id_valid && ctrl_wait) state <= DRAIN;
        DRAIN:   if (inflight_zero || !id_valid) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
